// File: rtl/normalizer.sv
// Iterative normalize / bit-count unit: CLZ, CTZ and CLS via a 5-step binary search
// (16/8/4/2/1), one step per cycle, with valid/ready handshakes on both sides.
module normalizer (
  input  logic        clk_i_nm,
  input  logic        rst_n_i_nm,
  input  logic        flush_i_nm,
  input  logic        valid_i_nm,
  output logic        ready_o_nm,
  input  logic [31:0] opr_i_nm,
  input  logic [1:0]  mode_i_nm,
  output logic        valid_o_nm,
  input  logic        ready_i_nm,
  output logic [31:0] rslt_o_nm,
  output logic [5:0]  cnt_o_nm,
  output logic [1:0]  rslt_cc_o_nm
);

  localparam int DATA_W = 32;
  localparam logic [1:0] MODE_CLZ = 2'b00;
  localparam logic [1:0] MODE_CTZ = 2'b01;
  localparam logic [1:0] MODE_RSV = 2'b10;
  localparam logic [1:0] MODE_CLS = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic [1:0]        m_q, m_d;
  logic [5:0]        c_q, c_d;
  logic              z_q, z_d;
  logic [2:0]        sel_q, sel_d;
  logic [4:0]        width;

  // True when the current step may shift by n without losing a significant bit.
  function automatic logic step_hit(input logic [DATA_W-1:0] w, input logic [1:0] m,
                                    input logic [4:0] n);
    logic [DATA_W-1:0] ones;
    ones = '1;
    case (m)
      MODE_CLZ: step_hit = (w & ~(ones >> n)) == '0;
      MODE_CTZ: step_hit = (w & ~(ones << n)) == '0;
      MODE_CLS: step_hit = ((w ^ {DATA_W{w[DATA_W-1]}}) & ~(ones >> ({1'b0, n} + 6'd1))) == '0;
      default:  step_hit = 1'b0;
    endcase
  endfunction

  assign width = 5'd16 >> sel_q;

  always_ff @(posedge clk_i_nm or negedge rst_n_i_nm) begin
    if (!rst_n_i_nm) begin
      state_q <= IDLE;
      w_q     <= '0;
      m_q     <= MODE_CLZ;
      c_q     <= '0;
      z_q     <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      m_q     <= m_d;
      c_q     <= c_d;
      z_q     <= z_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    m_d     = m_q;
    c_d     = c_q;
    z_d     = z_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (valid_i_nm && !flush_i_nm) begin
          w_d     = opr_i_nm;
          m_d     = mode_i_nm;
          c_d     = '0;
          z_d     = (opr_i_nm == '0);
          sel_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (step_hit(w_q, m_q, width)) begin
          w_d = (m_q == MODE_CTZ) ? (w_q >> width) : (w_q << width);
          c_d = c_q + {1'b0, width};
        end
        sel_d = sel_q + 3'd1;
        if (sel_q == 3'd4) state_d = DONE;
      end
      DONE: begin
        if (ready_i_nm) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i_nm) state_d = IDLE;
  end

  // Outputs read as zero except while a result is being offered.
  always_comb begin
    ready_o_nm   = (state_q == IDLE);
    valid_o_nm   = (state_q == DONE);
    rslt_o_nm    = '0;
    cnt_o_nm     = '0;
    rslt_cc_o_nm = '0;
    if (state_q == DONE) begin
      rslt_o_nm = (m_q == MODE_RSV) ? '1 : w_q;
      if (m_q == MODE_RSV)
        cnt_o_nm = '0;
      else if (z_q && (m_q == MODE_CLZ || m_q == MODE_CTZ))
        cnt_o_nm = 6'd32;
      else
        cnt_o_nm = c_q;
      rslt_cc_o_nm = {rslt_o_nm[DATA_W-1], z_q};
    end
  end

endmodule

// File: tb/tb_normalizer.sv
// Directed testbench for normalizer: per-mode vectors, latency, backpressure,
// flush and asynchronous reset.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] opr;
  logic [1:0]  mode;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] rslt;
  logic [5:0]  cnt;
  logic [1:0]  cc;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_rslt;
  logic [5:0]  got_cnt;
  logic [1:0]  got_cc;
  int          got_lat;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] op;
    logic [31:0] r;
    logic [5:0]  c;
    logic [1:0]  cc;
  } vec_t;

  always #5 clk = ~clk;

  normalizer dut (
    .clk_i_nm     (clk),
    .rst_n_i_nm   (rst_n),
    .flush_i_nm   (flush),
    .valid_i_nm   (valid_i),
    .ready_o_nm   (ready_o),
    .opr_i_nm     (opr),
    .mode_i_nm    (mode),
    .valid_o_nm   (valid_o),
    .ready_i_nm   (ready_i),
    .rslt_o_nm    (rslt),
    .cnt_o_nm     (cnt),
    .rslt_cc_o_nm (cc)
  );

  // Accept one request and wait (bounded) for the result; leaves it un-acknowledged.
  task automatic run_op(input logic [1:0] m, input logic [31:0] op);
    int n = 0;
    while (ready_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: ready_o=%b required 1", ready_o);
    end
    mode = m; opr = op; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    got_lat = 0;
    while (valid_o !== 1'b1 && got_lat < 20) begin
      @(posedge clk); #1; got_lat++;
    end
    got_rslt = rslt; got_cnt = cnt; got_cc = cc;
  endtask

  task automatic finish_op();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ready_o, valid_o, rslt, cnt, cc} !== {1'b1, 1'b0, 32'h0, 6'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b rslt=%h cnt=%0d cc=%b required 1 0 0 0 00",
               ready_o, valid_o, rslt, cnt, cc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_clz();
    vec_t v[3];
    v[0] = '{2'b00, 32'h0001_0000, 32'h8000_0000, 6'd15, 2'b10};
    v[1] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 6'd32, 2'b01};
    v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 6'd0,  2'b10};
    foreach (v[i]) begin
      run_op(v[i].m, v[i].op);
      checks++;
      if (got_lat != 5) begin
        errors++;
        $display("FAIL clz_latency[%0d]: got %0d cycles required 5", i, got_lat);
      end
      checks++;
      if ({got_rslt, got_cnt, got_cc} !== {v[i].r, v[i].c, v[i].cc}) begin
        errors++;
        $display("FAIL clz[%0d] op=%h: rslt=%h cnt=%0d cc=%b required %h %0d %b",
                 i, v[i].op, got_rslt, got_cnt, got_cc, v[i].r, v[i].c, v[i].cc);
      end
      finish_op();
    end
  endtask

  task automatic test_ctz();
    vec_t v[3];
    v[0] = '{2'b01, 32'h0000_0A00, 32'h0000_0005, 6'd9,  2'b00};
    v[1] = '{2'b01, 32'h0000_0000, 32'h0000_0000, 6'd32, 2'b01};
    v[2] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 6'd31, 2'b00};
    foreach (v[i]) begin
      run_op(v[i].m, v[i].op);
      checks++;
      if ({got_rslt, got_cnt, got_cc} !== {v[i].r, v[i].c, v[i].cc}) begin
        errors++;
        $display("FAIL ctz[%0d] op=%h: rslt=%h cnt=%0d cc=%b required %h %0d %b",
                 i, v[i].op, got_rslt, got_cnt, got_cc, v[i].r, v[i].c, v[i].cc);
      end
      finish_op();
    end
  endtask

  task automatic test_cls();
    vec_t v[4];
    v[0] = '{2'b11, 32'hFFFF_8001, 32'h8001_0000, 6'd16, 2'b10};
    v[1] = '{2'b11, 32'h0000_0001, 32'h4000_0000, 6'd30, 2'b00};
    v[2] = '{2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 6'd31, 2'b10};
    v[3] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 6'd31, 2'b01};
    foreach (v[i]) begin
      run_op(v[i].m, v[i].op);
      checks++;
      if ({got_rslt, got_cnt, got_cc} !== {v[i].r, v[i].c, v[i].cc}) begin
        errors++;
        $display("FAIL cls[%0d] op=%h: rslt=%h cnt=%0d cc=%b required %h %0d %b",
                 i, v[i].op, got_rslt, got_cnt, got_cc, v[i].r, v[i].c, v[i].cc);
      end
      finish_op();
    end
  endtask

  task automatic test_reserved();
    vec_t v[2];
    v[0] = '{2'b10, 32'h0000_1234, 32'hFFFF_FFFF, 6'd0, 2'b10};
    v[1] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 6'd0, 2'b11};
    foreach (v[i]) begin
      run_op(v[i].m, v[i].op);
      checks++;
      if ({got_rslt, got_cnt, got_cc} !== {v[i].r, v[i].c, v[i].cc}) begin
        errors++;
        $display("FAIL reserved[%0d] op=%h: rslt=%h cnt=%0d cc=%b required %h %0d %b",
                 i, v[i].op, got_rslt, got_cnt, got_cc, v[i].r, v[i].c, v[i].cc);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    run_op(2'b00, 32'h0001_0000);
    for (int i = 0; i < 10; i++) begin
      valid_i = (i % 2 == 0);
      opr     = 32'h0000_0F00 + i;
      mode    = 2'b01;
      @(posedge clk); #1;
      checks++;
      if ({valid_o, ready_o, rslt, cnt, cc} !== {1'b1, 1'b0, 32'h8000_0000, 6'd15, 2'b10}) begin
        errors++;
        $display("FAIL hold[%0d]: vld=%b rdy=%b rslt=%h cnt=%0d cc=%b required 1 0 80000000 15 10",
                 i, valid_o, ready_o, rslt, cnt, cc);
      end
    end
    valid_i = 1'b0;
    finish_op();
    checks++;
    if ({ready_o, valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL hold_release: rdy=%b vld=%b required 1 0", ready_o, valid_o);
    end
    // Back-to-back: accept on the very next edge after the handshake.
    run_op(2'b01, 32'h0000_0A00);
    checks++;
    if ({got_lat, got_rslt, got_cnt, got_cc} !== {32'd5, 32'h0000_0005, 6'd9, 2'b00}) begin
      errors++;
      $display("FAIL back_to_back: lat=%0d rslt=%h cnt=%0d cc=%b required 5 00000005 9 00",
               got_lat, got_rslt, got_cnt, got_cc);
    end
    finish_op();
  endtask

  task automatic test_flush();
    int seen_valid = 0;
    mode = 2'b01; opr = 32'h0000_0A00; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({ready_o, valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL flush_run: rdy=%b vld=%b required 1 0", ready_o, valid_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (valid_o === 1'b1) seen_valid++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_valid != 0) begin
      errors++;
      $display("FAIL flush_no_valid: valid_o seen %0d cycles required 0", seen_valid);
    end
    run_op(2'b00, 32'h0001_0000);
    checks++;
    if ({got_lat, got_rslt, got_cnt, got_cc} !== {32'd5, 32'h8000_0000, 6'd15, 2'b10}) begin
      errors++;
      $display("FAIL flush_next_op: lat=%0d rslt=%h cnt=%0d cc=%b required 5 80000000 15 10",
               got_lat, got_rslt, got_cnt, got_cc);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({ready_o, valid_o, rslt} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL flush_done: rdy=%b vld=%b rslt=%h required 1 0 00000000", ready_o, valid_o, rslt);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b11; opr = 32'h0000_0001; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_o, valid_o, rslt, cnt, cc} !== {1'b1, 1'b0, 32'h0, 6'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_run: rdy=%b vld=%b rslt=%h cnt=%0d cc=%b required 1 0 0 0 00",
               ready_o, valid_o, rslt, cnt, cc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(2'b11, 32'hFFFF_8001);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_o, valid_o, rslt, cnt, cc} !== {1'b1, 1'b0, 32'h0, 6'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_done: rdy=%b vld=%b rslt=%h cnt=%0d cc=%b required 1 0 0 0 00",
               ready_o, valid_o, rslt, cnt, cc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(2'b00, 32'h0001_0000);
    checks++;
    if ({got_lat, got_rslt, got_cnt, got_cc} !== {32'd5, 32'h8000_0000, 6'd15, 2'b10}) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d rslt=%h cnt=%0d cc=%b required 5 80000000 15 10",
               got_lat, got_rslt, got_cnt, got_cc);
    end
    finish_op();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    opr = '0; mode = 2'b00;
    test_reset();
    test_clz();
    test_ctz();
    test_cls();
    test_reserved();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
